// File: rtl/fleet_placement_checker.sv
// Battleship fleet-placement validator: walks every ship cell once per clock and
// flags out-of-board, overlapping and blocked-cell ships, plus an overall valid.
module fleet_placement_checker #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 10,
    parameter int unsigned NUM_SHIPS = 5,
    parameter int unsigned LEN_W = 3,
    parameter logic [NUM_SHIPS*LEN_W-1:0] SHIP_LENS = 15'h26E5,
    localparam int unsigned CW = $clog2(BOARD_W),
    localparam int unsigned RW = $clog2(BOARD_H),
    localparam int unsigned SW = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ship_we,
    input  logic [SW-1:0]        ship_idx,
    input  logic [RW-1:0]        ship_row,
    input  logic [CW-1:0]        ship_col,
    input  logic                 ship_vert,
    input  logic                 board_we,
    input  logic [RW-1:0]        board_row,
    input  logic [CW-1:0]        board_col,
    input  logic                 board_val,
    input  logic                 board_clr,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic [NUM_SHIPS-1:0] oob_mask,
    output logic [NUM_SHIPS-1:0] overlap_mask,
    output logic [NUM_SHIPS-1:0] blocked_mask
);

    localparam int unsigned Cells = BOARD_W * BOARD_H;
    localparam int unsigned IW    = $clog2(Cells);
    localparam int unsigned RLW   = RW + LEN_W;
    localparam int unsigned CLW   = CW + LEN_W;

    typedef enum logic [1:0] {StIdle, StClear, StScan, StDone} state_e;

    state_e               state_q;
    logic [RW-1:0]        ship_row_q  [NUM_SHIPS];
    logic [CW-1:0]        ship_col_q  [NUM_SHIPS];
    logic                 ship_vert_q [NUM_SHIPS];
    logic [LEN_W-1:0]     ship_len    [NUM_SHIPS];
    logic [Cells-1:0]     blocked_q;
    logic [Cells-1:0]     occ_q;
    logic [SW-1:0]        owner_q     [Cells];
    logic [SW-1:0]        s_q;
    logic [LEN_W-1:0]     k_q;
    logic                 busy_q, done_q, valid_q;
    logic [NUM_SHIPS-1:0] oob_q, ovl_q, blk_q;
    logic [NUM_SHIPS-1:0] oob_d, ovl_d, blk_d;

    logic [RLW-1:0]       r_full;
    logic [CLW-1:0]       c_full;
    logic                 in_bounds, claim, last_cell, last_ship;
    logic [IW-1:0]        idx, board_idx;
    logic                 ship_ok, board_ok;

    for (genvar g = 0; g < NUM_SHIPS; g++) begin : g_len
        assign ship_len[g] = SHIP_LENS[LEN_W*g +: LEN_W];
    end

    // Current scan cell, computed wide so an overhanging ship never wraps.
    always_comb begin
        r_full    = RLW'(ship_row_q[s_q]) + (ship_vert_q[s_q] ? RLW'(k_q) : '0);
        c_full    = CLW'(ship_col_q[s_q]) + (ship_vert_q[s_q] ? '0 : CLW'(k_q));
        in_bounds = (32'(r_full) < BOARD_H) && (32'(c_full) < BOARD_W);
        idx       = IW'(r_full) * IW'(BOARD_W) + IW'(c_full);
        last_cell = (k_q == ship_len[s_q] - LEN_W'(1));
        last_ship = (32'(s_q) == NUM_SHIPS - 1);
        oob_d     = oob_q;
        ovl_d     = ovl_q;
        blk_d     = blk_q;
        claim     = 1'b0;
        if (!in_bounds) begin
            oob_d[s_q] = 1'b1;
        end else begin
            if (blocked_q[idx]) blk_d[s_q] = 1'b1;
            if (occ_q[idx]) begin
                ovl_d[s_q]          = 1'b1;
                ovl_d[owner_q[idx]] = 1'b1;
            end else begin
                claim = 1'b1;
            end
        end
    end

    always_comb begin
        ship_ok   = ship_we && (32'(ship_idx) < NUM_SHIPS);
        board_ok  = board_we && (32'(board_row) < BOARD_H) && (32'(board_col) < BOARD_W);
        board_idx = IW'(board_row) * IW'(BOARD_W) + IW'(board_col);
    end

    // Ship placements and blocked map; only writable while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SHIPS; i++) begin
                ship_row_q[i]  <= '0;
                ship_col_q[i]  <= '0;
                ship_vert_q[i] <= 1'b0;
            end
            blocked_q <= '0;
        end else if (state_q == StIdle) begin
            if (ship_ok) begin
                ship_row_q[ship_idx]  <= ship_row;
                ship_col_q[ship_idx]  <= ship_col;
                ship_vert_q[ship_idx] <= ship_vert;
            end
            if (board_clr) begin
                blocked_q <= '0;
            end else if (board_ok) begin
                blocked_q[board_idx] <= board_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            occ_q   <= '0;
            for (int unsigned i = 0; i < Cells; i++) owner_q[i] <= '0;
            s_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            oob_q   <= '0;
            ovl_q   <= '0;
            blk_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= StClear;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        oob_q   <= '0;
                        ovl_q   <= '0;
                        blk_q   <= '0;
                    end
                end
                StClear: begin
                    occ_q <= '0;
                    for (int unsigned i = 0; i < Cells; i++) owner_q[i] <= '0;
                    s_q     <= '0;
                    k_q     <= '0;
                    state_q <= StScan;
                end
                StScan: begin
                    oob_q <= oob_d;
                    ovl_q <= ovl_d;
                    blk_q <= blk_d;
                    if (claim) begin
                        occ_q[idx]   <= 1'b1;
                        owner_q[idx] <= s_q;
                    end
                    if (last_cell) begin
                        k_q <= '0;
                        if (last_ship) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            valid_q <= ~|(oob_d | ovl_d | blk_d);
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end else begin
                        k_q <= k_q + LEN_W'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign valid        = valid_q;
    assign oob_mask     = oob_q;
    assign overlap_mask = ovl_q;
    assign blocked_mask = blk_q;

endmodule

// File: tb/tb_fleet_placement_checker.sv
// Bench for fleet_placement_checker: directed and randomized placements checked against
// a cell-list / pairwise-intersection model of the fleet.
module tb_fleet_placement_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ship_we, ship_vert, board_we, board_val, board_clr, start;
    logic [2:0] ship_idx;
    logic [3:0] ship_row, ship_col, board_row, board_col;
    logic       busy, done, valid;
    logic [4:0] oob_mask, overlap_mask, blocked_mask;

    logic       b_ship_we, b_ship_vert, b_start;
    logic [1:0] b_ship_idx;
    logic [2:0] b_ship_row, b_ship_col;
    logic       b_busy, b_done, b_valid;
    logic [2:0] b_oob, b_ovl, b_blk;

    int checks = 0;
    int failures = 0;

    int m_row [8];
    int m_col [8];
    bit m_vert [8];
    bit m_blk [16][16];
    int lens1 [8] = '{5, 4, 3, 3, 2, 0, 0, 0};
    int lens2 [8] = '{4, 3, 2, 0, 0, 0, 0, 0};

    fleet_placement_checker dut (
        .clk(clk), .rst(rst),
        .ship_we(ship_we), .ship_idx(ship_idx), .ship_row(ship_row), .ship_col(ship_col),
        .ship_vert(ship_vert),
        .board_we(board_we), .board_row(board_row), .board_col(board_col),
        .board_val(board_val), .board_clr(board_clr),
        .start(start), .busy(busy), .done(done), .valid(valid),
        .oob_mask(oob_mask), .overlap_mask(overlap_mask), .blocked_mask(blocked_mask)
    );

    fleet_placement_checker #(
        .BOARD_W(8), .BOARD_H(6), .NUM_SHIPS(3), .LEN_W(3), .SHIP_LENS(9'b010_011_100)
    ) dut2 (
        .clk(clk), .rst(rst),
        .ship_we(b_ship_we), .ship_idx(b_ship_idx), .ship_row(b_ship_row),
        .ship_col(b_ship_col), .ship_vert(b_ship_vert),
        .board_we(1'b0), .board_row(3'd0), .board_col(3'd0), .board_val(1'b0),
        .board_clr(1'b0),
        .start(b_start), .busy(b_busy), .done(b_done), .valid(b_valid),
        .oob_mask(b_oob), .overlap_mask(b_ovl), .blocked_mask(b_blk)
    );

    // Returns {blocked, overlap, oob}, 8 bits each, from ship cell lists.
    function automatic logic [23:0] model(input int n, input int w, input int h,
                                          input int lens [8]);
        logic [7:0] oob, ovl, blk;
        int cr [8][8];
        int cc [8][8];
        bit inb [8][8];
        oob = '0; ovl = '0; blk = '0;
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < lens[s]; k++) begin
                cr[s][k]  = m_row[s] + (m_vert[s] ? k : 0);
                cc[s][k]  = m_col[s] + (m_vert[s] ? 0 : k);
                inb[s][k] = (cr[s][k] < h) && (cc[s][k] < w);
                if (!inb[s][k]) oob[s] = 1'b1;
                else if (m_blk[cr[s][k]][cc[s][k]]) blk[s] = 1'b1;
            end
        end
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                for (int ka = 0; ka < lens[a]; ka++)
                    for (int kb = 0; kb < lens[b]; kb++)
                        if (inb[a][ka] && inb[b][kb] && cr[a][ka] == cr[b][kb] &&
                            cc[a][ka] == cc[b][kb]) begin
                            ovl[a] = 1'b1;
                            ovl[b] = 1'b1;
                        end
        return {blk, ovl, oob};
    endfunction

    function automatic logic [15:0] exp1();
        logic [23:0] m;
        m = model(5, 10, 10, lens1);
        return {~|(m[4:0] | m[12:8] | m[20:16]), m[4:0], m[12:8], m[20:16]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_row[i] = 0; m_col[i] = 0; m_vert[i] = 1'b0;
        end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) m_blk[r][c] = 1'b0;
    endtask

    task automatic write_ship(input int idx, input int r, input int c, input bit v);
        ship_we = 1'b1; ship_idx = 3'(idx); ship_row = 4'(r); ship_col = 4'(c); ship_vert = v;
        @(posedge clk); #1;
        ship_we = 1'b0;
        if (idx < 5) begin
            m_row[idx] = r; m_col[idx] = c; m_vert[idx] = v;
        end
    endtask

    task automatic write_cell(input int r, input int c, input bit val, input bit clr);
        board_we = 1'b1; board_row = 4'(r); board_col = 4'(c); board_val = val;
        board_clr = clr;
        @(posedge clk); #1;
        board_we = 1'b0; board_clr = 1'b0;
        if (clr) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) m_blk[i][j] = 1'b0;
        end else if (r < 10 && c < 10) begin
            m_blk[r][c] = val;
        end
    endtask

    // lat = cycle in which done is seen, counting the start-high cycle as 0.
    task automatic run_check(input bit disturb, output int lat, output logic busy1,
                             output logic done_after);
        start = 1'b1; lat = -1; busy1 = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin start = 1'b0; busy1 = busy; end
            if (disturb) begin
                if (i == 5) start = 1'b1;
                if (i == 6) start = 1'b0;
                if (i == 7) begin
                    ship_we = 1'b1; ship_idx = 3'd0; ship_row = 4'd9; ship_col = 4'd9;
                    ship_vert = 1'b1;
                end
                if (i == 8) ship_we = 1'b0;
            end
            if (done) begin lat = i; break; end
        end
        start = 1'b0; ship_we = 1'b0;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        got = {busy, done, valid, oob_mask, overlap_mask, blocked_mask};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want all zero", got);
        end
    endtask

    task automatic test_default_fleet();
        int lat; logic b1, da; logic [15:0] got, want;
        for (int i = 0; i < 5; i++) write_ship(i, i, 0, 1'b0);
        want = exp1();
        run_check(1'b0, lat, b1, da);
        got = {valid, oob_mask, overlap_mask, blocked_mask};
        checks++;
        if (lat !== 19) begin failures++; $display("FAIL default_latency: got %0d want 19", lat); end
        checks++;
        if (got !== 16'h8000) begin
            failures++; $display("FAIL default_result: got %h want 8000", got);
        end
        checks++;
        if (got !== want) begin
            failures++; $display("FAIL default_model: got %h want %h", got, want);
        end
        checks++;
        if ({b1, da} !== 2'b10) begin
            failures++; $display("FAIL busy_and_pulse: got busy=%b done_after=%b want 1 0", b1, da);
        end
    endtask

    task automatic test_oob();
        int lat; logic b1, da;
        write_ship(4, 3, 9, 1'b0);
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({valid, oob_mask, overlap_mask} !== 11'b0_10000_00000) begin
            failures++;
            $display("FAIL oob_edge: got v=%b oob=%b ovl=%b want 0 10000 00000",
                     valid, oob_mask, overlap_mask);
        end
        write_ship(4, 4, 0, 1'b0);
        write_ship(0, 6, 0, 1'b1);
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({oob_mask, overlap_mask} !== 10'b00001_00000) begin
            failures++;
            $display("FAIL oob_vert: got oob=%b ovl=%b want 00001 00000", oob_mask, overlap_mask);
        end
    endtask

    task automatic test_overlap();
        int lat; logic b1, da; logic [15:0] want;
        write_ship(0, 0, 0, 1'b0);
        write_ship(1, 0, 2, 1'b1);
        write_ship(2, 5, 0, 1'b0);
        write_ship(3, 6, 0, 1'b0);
        write_ship(4, 7, 0, 1'b0);
        want = exp1();
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({overlap_mask, blocked_mask, oob_mask} !== 15'b00011_00000_00000) begin
            failures++;
            $display("FAIL overlap: got ovl=%b blk=%b oob=%b want 00011 00000 00000",
                     overlap_mask, blocked_mask, oob_mask);
        end
        checks++;
        if ({valid, oob_mask, overlap_mask, blocked_mask} !== want) begin
            failures++; $display("FAIL overlap_model: got ovl=%b want %h", overlap_mask, want);
        end
    endtask

    task automatic test_blocked();
        int lat; logic b1, da;
        for (int i = 0; i < 4; i++) write_ship(i, i, 0, 1'b0);
        write_ship(4, 4, 0, 1'b0);
        write_cell(4, 1, 1'b1, 1'b0);
        write_cell(4, 12, 1'b1, 1'b0);
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({valid, blocked_mask} !== 6'b0_10000) begin
            failures++;
            $display("FAIL blocked: got v=%b blk=%b want 0 10000", valid, blocked_mask);
        end
        write_ship(4, 5, 1, 1'b0);
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({valid, blocked_mask} !== {exp1()[15], exp1()[4:0]}) begin
            failures++;
            $display("FAIL offboard_write: got v=%b blk=%b want 1 00000", valid, blocked_mask);
        end
        write_ship(4, 4, 0, 1'b0);
        write_cell(0, 0, 1'b0, 1'b1);
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({valid, blocked_mask} !== 6'b1_00000) begin
            failures++; $display("FAIL board_clr: got v=%b blk=%b want 1 00000", valid, blocked_mask);
        end
        write_cell(4, 1, 1'b1, 1'b1);
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({valid, blocked_mask} !== 6'b1_00000) begin
            failures++;
            $display("FAIL clr_priority: got v=%b blk=%b want 1 00000", valid, blocked_mask);
        end
    endtask

    task automatic test_busy_events();
        int lat; logic b1, da; logic [15:0] want;
        want = exp1();
        run_check(1'b1, lat, b1, da);
        checks++;
        if (lat !== 19) begin failures++; $display("FAIL restart_ignored: got %0d want 19", lat); end
        checks++;
        if ({valid, oob_mask, overlap_mask, blocked_mask} !== want) begin
            failures++;
            $display("FAIL busy_write: got %h want %h",
                     {valid, oob_mask, overlap_mask, blocked_mask}, want);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic b1, da;
        write_ship(2, 2, 0, 1'b1);
        run_check(1'b0, lat1, b1, da);
        run_check(1'b0, lat2, b1, da);
        checks++;
        if (lat1 !== 19 || lat2 !== 19) begin
            failures++; $display("FAIL back_to_back: got %0d %0d want 19 19", lat1, lat2);
        end
        checks++;
        if ({valid, oob_mask, overlap_mask, blocked_mask} !== exp1()) begin
            failures++; $display("FAIL back_to_back_result: got ovl=%b want %h",
                                 overlap_mask, exp1());
        end
    endtask

    task automatic test_random();
        int lat; logic b1, da; logic [15:0] want, got;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) write_cell(0, 0, 1'b0, 1'b1);
            for (int j = 0; j < 3; j++)
                write_cell($urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom), 1'b0);
            for (int j = 0; j < 6; j++)
                write_ship($urandom_range(0, 7), $urandom_range(0, 11),
                           $urandom_range(0, 11), 1'($urandom));
            want = exp1();
            run_check(1'b0, lat, b1, da);
            got = {valid, oob_mask, overlap_mask, blocked_mask};
            checks++;
            if (got !== want || lat !== 19) begin
                failures++;
                $display("FAIL random_%0d: got %h lat %0d want %h lat 19", it, got, lat, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic b1, da; logic seen; logic [17:0] got;
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
        end
        rst = 1'b1; #1;
        got = {busy, done, valid, oob_mask, overlap_mask, blocked_mask};
        checks++;
        if (got !== '0) begin failures++; $display("FAIL reset_mid: got %b want all zero", got); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        seen = 1'b0;
        repeat (30) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL reset_no_done: got %b want 0", seen); end
        run_check(1'b0, lat, b1, da);
        checks++;
        if ({valid, oob_mask, overlap_mask, blocked_mask} !== exp1()) begin
            failures++;
            $display("FAIL reset_ships: got ovl=%b want %h", overlap_mask, exp1());
        end
    endtask

    task automatic test_param_sweep();
        int lat; logic [23:0] m; logic [9:0] got, want;
        model_reset();
        m_row[0] = 0; m_col[0] = 0; m_vert[0] = 1'b0;
        m_row[1] = 1; m_col[1] = 0; m_vert[1] = 1'b0;
        m_row[2] = 5; m_col[2] = 7; m_vert[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_ship_we = 1'b1; b_ship_idx = 2'(i); b_ship_row = 3'(m_row[i]);
            b_ship_col = 3'(m_col[i]); b_ship_vert = m_vert[i];
            @(posedge clk); #1;
        end
        b_ship_we = 1'b0;
        m = model(3, 8, 6, lens2);
        want = {~|(m[2:0] | m[10:8] | m[18:16]), m[2:0], m[10:8], m[18:16]};
        b_start = 1'b1; lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) b_start = 1'b0;
            if (b_done) begin lat = i; break; end
        end
        got = {b_valid, b_oob, b_ovl, b_blk};
        checks++;
        if (lat !== 11) begin failures++; $display("FAIL sweep_latency: got %0d want 11", lat); end
        checks++;
        if (got !== want || b_oob !== 3'b100) begin
            failures++; $display("FAIL sweep_result: got %b want %b (oob 100)", got, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        ship_we = 0; ship_vert = 0; ship_idx = '0; ship_row = '0; ship_col = '0;
        board_we = 0; board_val = 0; board_clr = 0; board_row = '0; board_col = '0; start = 0;
        b_ship_we = 0; b_ship_vert = 0; b_start = 0; b_ship_idx = '0;
        b_ship_row = '0; b_ship_col = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_default_fleet();
        test_oob();
        test_overlap();
        test_blocked();
        test_busy_events();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
